// File: rtl/axis_stream_broadcaster_pkg.sv
// Shared types and defaults for the 1-to-2 AXI4-Stream broadcaster.
// A beat is the {last, data} pair carried through each master buffer.
package axis_stream_broadcaster_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int AXIS_FIFO_DEPTH = 2;

  typedef struct packed {
    logic                       last;
    logic [AXIS_DATA_WIDTH-1:0] data;
  } axis_beat_t;

endpackage

// File: rtl/axis_bcast_fifo.sv
// Single-clock FIFO with async active-low reset.
// The head output reads zero whenever the buffer is empty.
module axis_bcast_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axis_stream_broadcaster.sv
// 1-to-2 AXI4-Stream broadcaster: every accepted beat goes to both
// master buffers in the same edge; the masters drain independently.
module axis_stream_broadcaster
  import axis_stream_broadcaster_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int FIFO_DEPTH = AXIS_FIFO_DEPTH
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA1,
  output logic                  M_AXIS_TVALID1,
  output logic                  M_AXIS_TLAST1,
  input  logic                  M_AXIS_TREADY1,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA2,
  output logic                  M_AXIS_TVALID2,
  output logic                  M_AXIS_TLAST2,
  input  logic                  M_AXIS_TREADY2
);

  logic              rdy_q;
  logic              accept;
  logic              full1, full2;
  logic              empty1, empty2;
  logic [DATA_WIDTH:0] s_beat;
  logic [DATA_WIDTH:0] head1, head2;

  // Held low through reset and for the first edge after release.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) rdy_q <= 1'b0;
    else               rdy_q <= 1'b1;
  end

  assign S_AXIS_TREADY = rdy_q && !full1 && !full2;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign s_beat        = {S_AXIS_TLAST, S_AXIS_TDATA};

  axis_bcast_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk   (AXIS_ACLK),
    .rst_n (AXIS_ARESETN),
    .push  (accept),
    .pop   (M_AXIS_TVALID1 && M_AXIS_TREADY1),
    .din   (s_beat),
    .head  (head1),
    .full  (full1),
    .empty (empty1)
  );

  axis_bcast_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo2 (
    .clk   (AXIS_ACLK),
    .rst_n (AXIS_ARESETN),
    .push  (accept),
    .pop   (M_AXIS_TVALID2 && M_AXIS_TREADY2),
    .din   (s_beat),
    .head  (head2),
    .full  (full2),
    .empty (empty2)
  );

  assign M_AXIS_TVALID1 = !empty1;
  assign M_AXIS_TVALID2 = !empty2;
  assign {M_AXIS_TLAST1, M_AXIS_TDATA1} = head1;
  assign {M_AXIS_TLAST2, M_AXIS_TDATA2} = head2;

endmodule

// File: tb/tb_axis_stream_broadcaster.sv
// Scoreboard bench for axis_stream_broadcaster: accepted beats are
// queued for both ports and popped by a monitor on each output handshake.
module tb_axis_stream_broadcaster;
  import axis_stream_broadcaster_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] m_tdata1, m_tdata2;
  logic        m_tvalid1, m_tvalid2;
  logic        m_tlast1, m_tlast2;
  logic        m_tready1, m_tready2;

  always #5 clk = ~clk;

  axis_stream_broadcaster #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (2)
  ) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA1  (m_tdata1),
    .M_AXIS_TVALID1 (m_tvalid1),
    .M_AXIS_TLAST1  (m_tlast1),
    .M_AXIS_TREADY1 (m_tready1),
    .M_AXIS_TDATA2  (m_tdata2),
    .M_AXIS_TVALID2 (m_tvalid2),
    .M_AXIS_TLAST2  (m_tlast2),
    .M_AXIS_TREADY2 (m_tready2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  axis_beat_t exp1[$];
  axis_beat_t exp2[$];
  axis_beat_t o1, o2, e1, e2, sin;
  bit         hold1_v, hold2_v;
  axis_beat_t hold1_d, hold2_d;
  bit         rand_rdy = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: inputs are stable mid-cycle, so handshakes are judged here.
  always @(negedge clk) begin
    if (rst_n) begin
      o1  = '{last: m_tlast1, data: m_tdata1};
      o2  = '{last: m_tlast2, data: m_tdata2};
      sin = '{last: s_tlast, data: s_tdata};
      if (hold1_v) begin
        chk("hold_valid1", 64'(m_tvalid1), 64'd1);
        chk("hold_beat1", 64'(o1), 64'(hold1_d));
      end
      if (hold2_v) begin
        chk("hold_valid2", 64'(m_tvalid2), 64'd1);
        chk("hold_beat2", 64'(o2), 64'(hold2_d));
      end
      if (m_tvalid1 && m_tready1) begin
        if (exp1.size() == 0) fail_now("extra_beat1");
        else begin
          e1 = exp1.pop_front();
          chk("beat1", 64'(o1), 64'(e1));
        end
      end
      if (m_tvalid2 && m_tready2) begin
        if (exp2.size() == 0) fail_now("extra_beat2");
        else begin
          e2 = exp2.pop_front();
          chk("beat2", 64'(o2), 64'(e2));
        end
      end
      if (s_tvalid && s_tready) begin
        exp1.push_back(sin);
        exp2.push_back(sin);
      end
      hold1_v = m_tvalid1 && !m_tready1;
      hold2_v = m_tvalid2 && !m_tready2;
      hold1_d = o1;
      hold2_d = o2;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      m_tready1 = ($urandom_range(0, 3) != 0);
      m_tready2 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] d, input logic l,
                      output int cyc);
    bit ok;
    ok       = 0;
    cyc      = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      cyc++;
      if (ok) break;
    end
    s_tvalid = 1'b0;
    if (!ok) fail_now("send_timeout");
  endtask

  task automatic drain(input string nm);
    m_tready1 = 1'b1;
    m_tready2 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp1.size() == 0 && exp2.size() == 0) break;
    end
    chk(nm, 64'(exp1.size() + exp2.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, tot, stalls;
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, tot, stalls;
    rst_n     = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = 32'h1234_5678;
    s_tlast   = 1'b1;
    m_tready1 = 1'b1;
    m_tready2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_tvalid1", 64'(m_tvalid1), 64'd0);
    chk("rst_tvalid2", 64'(m_tvalid2), 64'd0);
    chk("rst_tdata1", 64'(m_tdata1), 64'd0);
    chk("rst_tdata2", 64'(m_tdata2), 64'd0);
    chk("rst_tlast1", 64'(m_tlast1), 64'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    chk("rel_tready_early", 64'(s_tready), 64'd0);
    @(negedge clk);
    chk("rel_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    // Single beat: visible on both ports for exactly one cycle.
    send(32'h00AB_CDEF, 1'b1, c);
    @(negedge clk);
    chk("single_valid1", 64'(m_tvalid1), 64'd1);
    chk("single_valid2", 64'(m_tvalid2), 64'd1);
    chk("single_data1", 64'(m_tdata1), 64'h00AB_CDEF);
    chk("single_data2", 64'(m_tdata2), 64'h00AB_CDEF);
    chk("single_last1", 64'(m_tlast1), 64'd1);
    chk("single_last2", 64'(m_tlast2), 64'd1);
    @(negedge clk);
    chk("single_gone1", 64'(m_tvalid1), 64'd0);
    chk("single_gone2", 64'(m_tvalid2), 64'd0);
    @(posedge clk);
    #1;

    // Streaming at full rate.
    tot    = 0;
    stalls = 0;
    for (int i = 1; i <= 256; i++) begin
      send(32'(i), (i % 2) == 0, c);
      tot += c;
      if (c != 1) stalls++;
    end
    chk("stream_cycles", 64'(tot), 64'd256);
    chk("stream_stalls", 64'(stalls), 64'd0);
    drain("stream_drain");

    // Backpressure on port 2.
    m_tready1 = 1'b1;
    m_tready2 = 1'b0;
    send(32'hA, 1'b0, c);
    send(32'hB, 1'b0, c);
    s_tdata  = 32'hC;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    @(negedge clk);
    chk("bp_tready_low", 64'(s_tready), 64'd0);
    repeat (3) @(negedge clk);
    chk("bp_tready_still_low", 64'(s_tready), 64'd0);
    chk("bp_port1_empty", 64'(m_tvalid1), 64'd0);
    chk("bp_port2_valid", 64'(m_tvalid2), 64'd1);
    chk("bp_port2_head", 64'(m_tdata2), 64'hA);
    @(posedge clk);
    #1;
    m_tready2 = 1'b1;
    send(32'hC, 1'b1, c);
    drain("bp_drain");

    // Reset with two beats held on port 2.
    m_tready1 = 1'b1;
    m_tready2 = 1'b0;
    send(32'h77, 1'b0, c);
    send(32'h88, 1'b1, c);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid2", 64'(m_tvalid2), 64'd0);
    chk("midrst_tvalid1", 64'(m_tvalid1), 64'd0);
    chk("midrst_tready", 64'(s_tready), 64'd0);
    exp1.delete();
    exp2.delete();
    hold1_v = 0;
    hold2_v = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_tready2 = 1'b1;
    send(32'h5555, 1'b1, c);
    @(negedge clk);
    chk("postrst_valid2", 64'(m_tvalid2), 64'd1);
    chk("postrst_first2", 64'(m_tdata2), 64'h5555);
    chk("postrst_first1", 64'(m_tdata1), 64'h5555);
    @(posedge clk);
    #1;
    drain("postrst_drain");

    // Random traffic with random backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send($urandom, 1'($urandom_range(0, 1)), c);
    end
    rand_rdy = 0;
    @(posedge clk);
    #2;
    drain("rand_drain");
    @(negedge clk);
    chk("final_idle1", 64'(m_tvalid1), 64'd0);
    chk("final_idle2", 64'(m_tvalid2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
